// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low abcdefg hex patterns, nibble width,
// and the scan decoder FSM state type.
package seg7_pkg;

    localparam int NIBBLE_W = 4;

    // Pattern bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
    localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
    localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
    localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
    localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b1100000;
    localparam logic [6:0] SEG_HEX_C = 7'b0110001;
    localparam logic [6:0] SEG_HEX_D = 7'b1000010;
    localparam logic [6:0] SEG_HEX_E = 7'b0110000;
    localparam logic [6:0] SEG_HEX_F = 7'b0111000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_LOCKED   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex seven-segment encoder: pattern in, nibble and
// hit flag out. Any pattern outside the 16-entry table reports hit = 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0]          pattern,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                hit
);

    always_comb begin
        nibble = '0;
        hit    = 1'b1;
        case (pattern)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            default:   hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low seven-segment bus, waits for each digit's pattern
// to be stable, then decodes it into a per-digit nibble. Decimal point: SEG7_SCAN_DP_EN.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:7]                   seg_in,
    input  logic [DIGITS-1:0]            dig_sel,
`ifdef SEG7_SCAN_DP_EN
    input  logic                         dp_in,
    output logic [DIGITS-1:0]            dp_valid,
`endif
    output logic [NIBBLE_W*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]            digit_valid,
    output logic                         update,
    output logic                         err,
    output scan_state_t                  fsm_state
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [6:0]          smp_seg, prev_seg;
    logic [DIGITS-1:0]   smp_sel, prev_sel;
    logic [7:0]          cnt, cnt_next;
    logic                sel_onehot;
    logic                changed;
    logic                commit;
    logic [NIBBLE_W-1:0] dec_nibble;
    logic                dec_hit;
    scan_state_t         state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_seg  <= '1;
            prev_seg <= '1;
            smp_sel  <= '0;
            prev_sel <= '0;
        end else begin
            smp_seg  <= seg_in;
            prev_seg <= smp_seg;
            smp_sel  <= dig_sel;
            prev_sel <= smp_sel;
        end
    end

`ifdef SEG7_SCAN_DP_EN
    logic smp_dp, prev_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_dp  <= 1'b1;
            prev_dp <= 1'b1;
        end else begin
            smp_dp  <= dp_in;
            prev_dp <= smp_dp;
        end
    end

    assign changed = (smp_seg != prev_seg) || (smp_sel != prev_sel) || (smp_dp != prev_dp);
`else
    assign changed = (smp_seg != prev_seg) || (smp_sel != prev_sel);
`endif

    assign sel_onehot = $onehot(smp_sel);

    always_comb begin
        cnt_next = cnt;
        if (changed || !sel_onehot) begin
            cnt_next = 8'd1;
        end else if (cnt >= STABLE) begin
            cnt_next = STABLE;
        end else begin
            cnt_next = cnt + 8'd1;
        end
    end

    // The commit fires on the edge the counter reaches the threshold, so a sample
    // change landing on that same edge suppresses it.
    assign commit = (state == ST_SETTLING) && sel_onehot && !changed && (cnt_next == STABLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (sel_onehot) state_next = ST_SETTLING;
            end
            ST_SETTLING: begin
                if (!sel_onehot)  state_next = ST_IDLE;
                else if (commit)  state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!sel_onehot)  state_next = ST_IDLE;
                else if (changed) state_next = ST_SETTLING;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fsm_state = state;

    seg7_pattern_decode u_decode (
        .pattern (smp_seg),
        .nibble  (dec_nibble),
        .hit     (dec_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value       <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            err         <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_valid    <= '0;
`endif
        end else begin
            update <= commit && dec_hit;
            err    <= commit && !dec_hit;
            if (commit) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (smp_sel[i]) begin
                        // A miss keeps the old nibble but withdraws its validity.
                        if (dec_hit) value[NIBBLE_W*i +: NIBBLE_W] <= dec_nibble;
                        digit_valid[i] <= dec_hit;
`ifdef SEG7_SCAN_DP_EN
                        dp_valid[i]    <= dec_hit && !smp_dp;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4); the
// decimal-point scenario is built only when SEG7_SCAN_DP_EN is defined.
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:7]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        update;
    logic        err;
    scan_state_t fsm_state;
`ifdef SEG7_SCAN_DP_EN
    logic        dp_in;
    logic [3:0]  dp_valid;
`endif

    int checks   = 0;
    int failures = 0;
    int upd_seen = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
`ifdef SEG7_SCAN_DP_EN
        .dp_in       (dp_in),
        .dp_valid    (dp_valid),
`endif
        .value       (value),
        .digit_valid (digit_valid),
        .update      (update),
        .err         (err),
        .fsm_state   (fsm_state)
    );

    // Pulses span a full clock, so each is seen exactly once on the falling edge.
    always @(negedge clk) begin
        if (update) upd_seen++;
        if (err)    err_seen++;
    end

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] pat);
        @(negedge clk);
        dig_sel = sel;
        seg_in  = pat;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        seg_in  = 7'b1111111;
        dig_sel = 4'b0000;
`ifdef SEG7_SCAN_DP_EN
        dp_in   = 1'b1;
`endif
        edges(3);
        checks++; if (value !== 16'h0)       begin failures++; $display("FAIL reset_value: got %h want 0000", value); end
        checks++; if (digit_valid !== 4'h0)  begin failures++; $display("FAIL reset_valid: got %b want 0000", digit_valid); end
        checks++; if (update !== 1'b0)       begin failures++; $display("FAIL reset_update: got %b want 0", update); end
        checks++; if (err !== 1'b0)          begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_latency;
        drive(4'b0001, 7'b0010010);
        // Edge k=1 captures the sample; commit is registered four edges later.
        for (int k = 1; k <= 6; k++) begin
            edges(1);
            checks++;
            if (update !== (k == 5)) begin
                failures++;
                $display("FAIL latency_edge%0d: update=%b want %b", k, update, (k == 5));
            end
        end
        checks++; if (value[3:0] !== 4'h2)    begin failures++; $display("FAIL latency_value: got %h want 2", value[3:0]); end
        checks++; if (digit_valid !== 4'b0001) begin failures++; $display("FAIL latency_valid: got %b want 0001", digit_valid); end
    endtask

    task automatic test_scan;
        int u0 = upd_seen;
        int e0 = err_seen;
        drive(4'b1000, 7'b0111000); edges(6);
        drive(4'b0100, 7'b0000001); edges(6);
        drive(4'b0010, 7'b0000000); edges(6);
        drive(4'b0001, 7'b0001000); edges(6);
        checks++; if (value !== 16'hF08A)       begin failures++; $display("FAIL scan_value: got %h want F08A", value); end
        checks++; if (digit_valid !== 4'b1111)  begin failures++; $display("FAIL scan_valid: got %b want 1111", digit_valid); end
        checks++; if (upd_seen - u0 !== 4)      begin failures++; $display("FAIL scan_updates: got %0d want 4", upd_seen - u0); end
        checks++; if (err_seen - e0 !== 0)      begin failures++; $display("FAIL scan_errs: got %0d want 0", err_seen - e0); end
    endtask

    task automatic test_miss;
        int u0 = upd_seen;
        int e0 = err_seen;
        drive(4'b0010, 7'b1111111); edges(8);
        checks++; if (err_seen - e0 !== 1)     begin failures++; $display("FAIL miss_errs: got %0d want 1", err_seen - e0); end
        checks++; if (upd_seen - u0 !== 0)     begin failures++; $display("FAIL miss_updates: got %0d want 0", upd_seen - u0); end
        checks++; if (digit_valid !== 4'b1101) begin failures++; $display("FAIL miss_valid: got %b want 1101", digit_valid); end
        checks++; if (value !== 16'hF08A)      begin failures++; $display("FAIL miss_value: got %h want F08A", value); end
    endtask

    task automatic test_no_commit;
        int u0 = upd_seen;
        int e0 = err_seen;
        for (int t = 0; t < 6; t++) begin
            drive(4'b0001, (t % 2 == 0) ? 7'b1001111 : 7'b0001111);
            edges(3);
        end
        drive(4'b0011, 7'b0000110); edges(8);
        checks++; if (upd_seen - u0 !== 0)     begin failures++; $display("FAIL nocommit_updates: got %0d want 0", upd_seen - u0); end
        checks++; if (err_seen - e0 !== 0)     begin failures++; $display("FAIL nocommit_errs: got %0d want 0", err_seen - e0); end
        checks++; if (fsm_state !== ST_IDLE)   begin failures++; $display("FAIL nocommit_state: got %0d want %0d", fsm_state, ST_IDLE); end
        checks++; if (value !== 16'hF08A)      begin failures++; $display("FAIL nocommit_value: got %h want F08A", value); end
        checks++; if (digit_valid !== 4'b1101) begin failures++; $display("FAIL nocommit_valid: got %b want 1101", digit_valid); end
    endtask

    task automatic test_reset_mid;
        int u0;
        drive(4'b0100, 7'b1001100);
        edges(4);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (value !== 16'h0)       begin failures++; $display("FAIL midreset_value: got %h want 0000", value); end
        checks++; if (digit_valid !== 4'h0)  begin failures++; $display("FAIL midreset_valid: got %b want 0000", digit_valid); end
        checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL midreset_state: got %0d want %0d", fsm_state, ST_IDLE); end
        u0 = upd_seen;
        edges(2);
        checks++; if (update !== 1'b0 || upd_seen != u0) begin failures++; $display("FAIL midreset_update: got %0d pulses want 0", upd_seen - u0); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            edges(1);
            checks++;
            if (update !== (k == 5)) begin
                failures++;
                $display("FAIL midreset_edge%0d: update=%b want %b", k, update, (k == 5));
            end
        end
        checks++; if (value !== 16'h0400)      begin failures++; $display("FAIL midreset_value2: got %h want 0400", value); end
        checks++; if (digit_valid !== 4'b0100) begin failures++; $display("FAIL midreset_valid2: got %b want 0100", digit_valid); end
    endtask

`ifdef SEG7_SCAN_DP_EN
    task automatic test_dp;
        @(negedge clk);
        dp_in = 1'b0;
        dig_sel = 4'b0001;
        seg_in  = 7'b0100100;
        edges(6);
        checks++; if (value[3:0] !== 4'h5)   begin failures++; $display("FAIL dp_value: got %h want 5", value[3:0]); end
        checks++; if (dp_valid !== 4'b0001)  begin failures++; $display("FAIL dp_valid: got %b want 0001", dp_valid); end
        drive(4'b0001, 7'b1111111); edges(6);
        checks++; if (dp_valid !== 4'b0000)  begin failures++; $display("FAIL dp_miss: got %b want 0000", dp_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_scan();
        test_miss();
        test_no_commit();
        test_reset_mid();
`ifdef SEG7_SCAN_DP_EN
        test_dp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
